// File: rtl/fetch_unit.sv
// Instruction fetch front end: a PC register drives a 1-cycle-latency instruction memory.
// A 2-entry output FIFO is kept from overflowing by issuing only when a slot is guaranteed.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h80000000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr
);

    localparam logic [2:0] DEPTH_L = 3'(DEPTH);

    logic [31:0] pc_q, pc_d;
    logic        inflight_q, inflight_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;
    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [31:0] buf_pc_q    [2];
    logic [31:0] buf_instr_q [2];

    logic        out_fire;
    logic        issue;
    logic        push;
    logic        pop;
    logic [2:0]  credit;

    assign imem_addr = pc_q;
    assign out_valid = ~rst & (count_q != 2'd0) & ~redirect_valid;
    assign out_pc    = rst ? 32'h0 : buf_pc_q[rd_ptr_q];
    assign out_instr = rst ? 32'h0 : buf_instr_q[rd_ptr_q];

    always_comb begin
        out_fire = out_valid & out_ready;
        // Occupancy the buffer will be committed to once this cycle's events settle.
        credit   = 3'(count_q) + 3'(inflight_q) - 3'(out_fire);
        issue    = ~redirect_valid & (credit < DEPTH_L);
        push     = inflight_q & ~redirect_valid;
        pop      = out_fire;
    end

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        count_d       = count_q + 2'(push) - 2'(pop);
        rd_ptr_d      = rd_ptr_q ^ pop;
        wr_ptr_d      = wr_ptr_q ^ push;
        if (redirect_valid) begin
            pc_d     = {redirect_pc[31:2], 2'b00};
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else if (issue) begin
            pc_d          = pc_q + 32'd4;
            inflight_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= {RESET_PC[31:2], 2'b00};
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0;
            count_q       <= 2'd0;
            rd_ptr_q      <= 1'b0;
            wr_ptr_q      <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                buf_pc_q[i]    <= 32'h0;
                buf_instr_q[i] <= 32'h0;
            end
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            if (push) begin
                buf_pc_q[wr_ptr_q]    <= inflight_pc_q;
                buf_instr_q[wr_ptr_q] <= imem_data;
            end
        end
    end

endmodule
